// File: rtl/match_counter.sv
// match_counter: counts rising edges of the 1011 detector's match output
// in a two-digit BCD counter (00-99). Drives active-low 7-segment digits,
// a stretched match LED, a sticky wrap flag and a threshold flag.
// Everything runs in the detector's clock domain, so match_in is used directly.
module match_counter #(
  parameter int LED_CYCLES = 4,
  parameter int THRESHOLD  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       match_in,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] count_ones,
  output logic [3:0] count_tens,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic       match_led,
  output logic       overflow,
  output logic       reached
);

  localparam logic [7:0] LED_LOAD = 8'(LED_CYCLES);
  localparam logic [7:0] THRESH   = 8'(THRESHOLD);

  logic       match_prev;
  logic       match_event;
  logic [7:0] led_timer;
  logic [7:0] count_bin;

  // A rise seen while enable is low is consumed by match_prev and never counted.
  assign match_event = match_in & ~match_prev & enable;

  // Previous-cycle copy of match_in, tracked regardless of enable or clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match_prev <= 1'b0;
    end else begin
      match_prev <= match_in;
    end
  end

  // BCD counter, sticky overflow and LED stretch timer; clear beats a same-cycle event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_ones <= 4'd0;
      count_tens <= 4'd0;
      overflow   <= 1'b0;
      led_timer  <= 8'd0;
    end else if (clear) begin
      count_ones <= 4'd0;
      count_tens <= 4'd0;
      overflow   <= 1'b0;
      led_timer  <= 8'd0;
    end else if (match_event) begin
      led_timer <= LED_LOAD;
      if (count_ones != 4'd9) begin
        count_ones <= count_ones + 4'd1;
      end else if (count_tens != 4'd9) begin
        count_ones <= 4'd0;
        count_tens <= count_tens + 4'd1;
      end else begin
        count_ones <= 4'd0;
        count_tens <= 4'd0;
        overflow   <= 1'b1;
      end
    end else if (led_timer != 8'd0) begin
      led_timer <= led_timer - 8'd1;
    end
  end

  assign match_led = (led_timer != 8'd0);

  // tens*10 + ones as shifts and adds; at most 99, so 8 bits is ample.
  assign count_bin = {1'b0, count_tens, 3'b000} + {3'b000, count_tens, 1'b0} + {4'b0000, count_ones};
  assign reached   = (count_bin >= THRESH);

  // Active-low segments {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign hex0 = seg7(count_ones);
  assign hex1 = seg7(count_tens);

endmodule

// File: tb/tb_match_counter.sv
// Testbench for match_counter: directed scenarios plus randomized traffic,
// checked every cycle against an integer-count behavioural model.
module tb_match_counter;

  localparam int LED_CYCLES = 4;
  localparam int THRESHOLD  = 10;

  logic       clock;
  logic       reset;
  logic       match_in;
  logic       enable;
  logic       clear;
  logic [3:0] count_ones;
  logic [3:0] count_tens;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic       match_led;
  logic       overflow;
  logic       reached;

  match_counter #(.LED_CYCLES(LED_CYCLES), .THRESHOLD(THRESHOLD)) dut (
    .clock      (clock),
    .reset      (reset),
    .match_in   (match_in),
    .enable     (enable),
    .clear      (clear),
    .count_ones (count_ones),
    .count_tens (count_tens),
    .hex0       (hex0),
    .hex1       (hex1),
    .match_led  (match_led),
    .overflow   (overflow),
    .reached    (reached)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Segment patterns for digits 0-9, written out from the display encoding.
  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  // Model: plain integer count 0..99, sticky wrap flag, remaining LED cycles.
  int m_count;
  int m_ovf;
  int m_led;
  int m_prev;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_count = 0; m_ovf = 0; m_led = 0; m_prev = 0;
    end else begin
      int rise;
      rise = (match_in == 1'b1 && m_prev == 0 && enable == 1'b1) ? 1 : 0;
      m_prev = int'(match_in);
      if (clear) begin
        m_count = 0; m_ovf = 0; m_led = 0;
      end else if (rise == 1) begin
        if (m_count == 99) begin
          m_count = 0; m_ovf = 1;
        end else begin
          m_count = m_count + 1;
        end
        m_led = LED_CYCLES;
      end else if (m_led > 0) begin
        m_led = m_led - 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  bit chk_en = 1'b0;
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      check("ones", int'(count_ones), m_count % 10);
      check("tens", int'(count_tens), m_count / 10);
      check("hex0", int'(hex0), int'(seg_tab[m_count % 10]));
      check("hex1", int'(hex1), int'(seg_tab[m_count / 10]));
      check("led", int'(match_led), (m_led > 0) ? 1 : 0);
      check("overflow", int'(overflow), m_ovf);
      check("reached", int'(reached), (m_count >= THRESHOLD) ? 1 : 0);
    end
  end

  task automatic step(input logic mi, input logic en, input logic cl);
    @(negedge clock);
    match_in = mi;
    enable   = en;
    clear    = cl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  int led_hi;

  initial begin
    reset = 1'b1; match_in = 1'b0; enable = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ones", int'(count_ones), 0);
    check("rst_tens", int'(count_tens), 0);
    check("rst_hex0", int'(hex0), int'(7'b1000000));
    check("rst_hex1", int'(hex1), int'(7'b1000000));
    check("rst_led", int'(match_led), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_reached", int'(reached), 0);
    @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;

    // Three single-cycle pulses, three cycles apart.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      idle(2);
    end
    check("p3_ones", int'(count_ones), 3);
    check("p3_hex0", int'(hex0), int'(7'b0110000));
    check("p3_hex1", int'(hex1), int'(7'b1000000));
    check("p3_ovf", int'(overflow), 0);
    check("p3_model", m_count, 3);

    // Level held ten cycles counts once; LED high for LED_CYCLES samples.
    idle(6);
    led_hi = 0;
    for (int i = 0; i < 12; i++) begin
      step((i < 10) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      if (match_led) led_hi++;
    end
    check("hold_ones", int'(count_ones), 4);
    check("hold_led_cycles", led_hi, 4);

    // Hundred pulses from zero: threshold, 99, then wrap.
    step(1'b0, 1'b1, 1'b1);
    idle(1);
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b1, 1'b0);
      idle(2);
      if (i == 9) check("p9_reached", int'(reached), 0);
      if (i == 10) check("p10_reached", int'(reached), 1);
      if (i == 99) begin
        check("p99_tens", int'(count_tens), 9);
        check("p99_ones", int'(count_ones), 9);
        check("p99_ovf", int'(overflow), 0);
      end
    end
    check("wrap_tens", int'(count_tens), 0);
    check("wrap_ones", int'(count_ones), 0);
    check("wrap_ovf", int'(overflow), 1);
    check("wrap_reached", int'(reached), 0);
    check("wrap_model_ovf", m_ovf, 1);
    step(1'b0, 1'b1, 1'b1);
    idle(1);
    check("clr_ovf", int'(overflow), 0);

    // Rise while disabled is never counted; next rise with enable counts.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("dis_ones", int'(count_ones), 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(1);
    check("en_ones", int'(count_ones), 1);

    // Clear beats a simultaneous rise.
    idle(6);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("clrev_ones", int'(count_ones), 0);
    check("clrev_led", int'(match_led), 0);

    // Retrigger two cycles into the LED window: LED high 4 samples from the second edge.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    led_hi = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (match_led) led_hi++;
    end
    check("retrig_led_cycles", led_hi, 4);
    check("retrig_ones", int'(count_ones), 2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 59) == 0));
    end

    // Asynchronous reset between edges at count 57.
    step(1'b0, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 57; i++) begin
      step(1'b1, 1'b1, 1'b0);
      idle(2);
    end
    check("c57_tens", int'(count_tens), 5);
    check("c57_ones", int'(count_ones), 7);
    #2;
    reset = 1'b1;
    #1;
    check("ar_ones", int'(count_ones), 0);
    check("ar_tens", int'(count_tens), 0);
    check("ar_hex0", int'(hex0), int'(7'b1000000));
    check("ar_hex1", int'(hex1), int'(7'b1000000));
    check("ar_led", int'(match_led), 0);
    check("ar_ovf", int'(overflow), 0);
    check("ar_reached", int'(reached), 0);
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    idle(2);
    check("resume_ones", int'(count_ones), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
